// File: rtl/vector_ram_if.sv
`default_nettype none
// ============================================================================
//  Module   : vector_ram_if
//  Purpose  : Request/response bundle for vector_ram. The master issues a
//             vector load/store request with a ready/valid handshake. The
//             slave returns a one-cycle completion pulse and the packed load
//             result.
//  Signals  : req, we, address, stride, wd, be  (master -> slave)
//             ready, valid, rd                  (slave -> master)
//  Revision : 1.0  initial release
// ============================================================================
interface vector_ram_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int LANES  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) ();
    logic                        req;
    logic                        we;
    logic [ADDR_W-1:0]           address;
    logic [ADDR_W-1:0]           stride;
    logic [LANES*WIDTH-1:0]      wd;
    logic [LANES*(WIDTH/8)-1:0]  be;
    logic                        ready;
    logic                        valid;
    logic [LANES*WIDTH-1:0]      rd;

    modport master (
        output req, we, address, stride, wd, be,
        input  ready, valid, rd
    );

    modport slave (
        input  req, we, address, stride, wd, be,
        output ready, valid, rd
    );
endinterface
`default_nettype wire

// File: rtl/vector_ram.sv
`default_nettype none
// ============================================================================
//  Module   : vector_ram
//  Purpose  : DEPTH x WIDTH word memory with vector access. One accepted
//             request loads or stores LANES words at base + k*stride
//             (mod DEPTH), one lane per cycle, with per-byte write enables.
//             LANES=1 gives a scalar RAM with a handshake.
//  Ports    : clk  - clock, rising-edge
//             rst  - synchronous active-high reset
//             bus  - vector_ram_if.slave (req/we/address/stride/wd/be in,
//                    ready/valid/rd out)
//  Revision : 1.0  initial release
// ============================================================================
module vector_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 1024,
    parameter int LANES  = 4,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic    clk,
    input  wire logic    rst,
    vector_ram_if.slave  bus
);

    localparam int c_bpw    = WIDTH / 8;
    localparam int c_lane_w = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_busy = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]                 r_state;
    logic [c_lane_w-1:0]        r_lane;
    logic                       r_we;
    logic [ADDR_W-1:0]          r_base;
    logic [ADDR_W-1:0]          r_stride;
    logic [LANES*WIDTH-1:0]     r_wd;
    logic [LANES*c_bpw-1:0]     r_be;
    logic [LANES*WIDTH-1:0]     r_rd;
    logic [WIDTH-1:0]           r_mem [DEPTH];

    logic [ADDR_W-1:0]          w_offset;
    logic [ADDR_W-1:0]          w_sum;
    logic [ADDR_W-1:0]          w_addr;
    logic                       w_wr_en;
    logic [WIDTH-1:0]           w_lane_wd;
    logic [c_bpw-1:0]           w_lane_be;

    // Lane address is formed from the latched base each cycle rather than
    // accumulated, so the ADDR_W-bit wrap behaves identically for every lane.
    assign w_offset = ADDR_W'(r_lane) * r_stride;
    assign w_sum    = r_base + w_offset;

    generate
        if ((DEPTH & (DEPTH - 1)) == 0) begin : g_addr_pow2
            // ADDR_W-bit overflow already wraps modulo DEPTH.
            assign w_addr = w_sum;
        end else begin : g_addr_mod
            localparam logic [ADDR_W-1:0] c_depth = ADDR_W'(DEPTH);
            assign w_addr = w_sum % c_depth;
        end
    endgenerate

    assign w_lane_wd = r_wd[r_lane*WIDTH +: WIDTH];
    assign w_lane_be = r_be[r_lane*c_bpw +: c_bpw];

    // Writes are squashed while rst is high so an aborted store leaves the
    // lanes it has not reached untouched.
    assign w_wr_en = (r_state == c_st_busy) && r_we && !rst;

    assign bus.ready = (r_state == c_st_idle) && !rst;
    assign bus.valid = (r_state == c_st_done) && !rst;
    assign bus.rd    = r_rd;

    // Storage: no reset, byte-granular write.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < c_bpw; b++) begin
                if (w_lane_be[b]) begin
                    r_mem[w_addr][b*8 +: 8] <= w_lane_wd[b*8 +: 8];
                end
            end
        end
    end

    // Sequencer: IDLE -> BUSY (LANES cycles) -> DONE (1 cycle) -> IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_lane  <= '0;
            r_rd    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (bus.req) begin
                        r_we     <= bus.we;
                        r_base   <= bus.address;
                        r_stride <= bus.stride;
                        r_wd     <= bus.wd;
                        r_be     <= bus.be;
                        r_lane   <= '0;
                        r_state  <= c_st_busy;
                    end
                end
                c_st_busy: begin
                    if (!r_we) begin
                        r_rd[r_lane*WIDTH +: WIDTH] <= r_mem[w_addr];
                    end
                    if (r_lane == c_lane_w'(LANES - 1)) begin
                        r_lane  <= '0;
                        r_state <= c_st_done;
                    end else begin
                        r_lane  <= r_lane + c_lane_w'(1);
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vector_ram
//  Purpose  : Directed self-checking bench for vector_ram (32-bit words,
//             1024 words, 4 lanes). Expected values are hand-computed.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vector_ram;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 1024;
    localparam int LANES  = 4;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst;
    int   n_total = 0;
    int   n_bad   = 0;

    logic [127:0] rdv;
    int           vcnt;

    always #5 clk = ~clk;

    vector_ram_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)) bus ();

    vector_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LANES(LANES), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete request. Inputs change on the falling edge; outputs are
    // sampled on the falling edge after each rising edge e0+j.
    task automatic xfer(input string tag, input logic w, input logic [9:0] a,
                        input logic [9:0] s, input logic [127:0] d,
                        input logic [15:0] b, input bit poke,
                        output logic [127:0] r);
        int vc, vpos, rlow;
        @(negedge clk);
        check({tag, "_ready_before"}, {127'b0, bus.ready}, 128'd1);
        bus.req = 1'b1; bus.we = w; bus.address = a; bus.stride = s;
        bus.wd = d; bus.be = b;
        @(posedge clk);
        vc = 0; vpos = -1; rlow = 0; r = '0;
        for (int j = 0; j <= LANES + 1; j++) begin
            @(negedge clk);
            if (bus.valid) begin vc++; vpos = j; r = bus.rd; end
            if (!bus.ready) rlow++;
            if (j == 0) bus.req = 1'b0;
            if (poke && j == 1) begin
                bus.req = 1'b1; bus.we = 1'b1;
                bus.wd = {4{32'h55555555}}; bus.be = 16'hFFFF;
            end
            if (poke && j == 2) bus.req = 1'b0;
        end
        check({tag, "_valid_count"}, 128'(vc), 128'd1);
        check({tag, "_valid_pos"}, 128'(vpos), 128'(LANES));
        check({tag, "_ready_low"}, 128'(rlow), 128'(LANES + 1));
    endtask

    initial begin
        bus.req = 1'b1; bus.we = 1'b1; bus.address = '0; bus.stride = 10'd1;
        bus.wd = {4{32'hDEADBEEF}}; bus.be = 16'hFFFF;

        // Reset held two cycles with REQ asserted.
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_ready_low", {127'b0, bus.ready}, 128'd0);
        check("rst_valid_low", {127'b0, bus.valid}, 128'd0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0; bus.req = 1'b0;
        @(negedge clk);
        check("rst_ready", {127'b0, bus.ready}, 128'd1);
        check("rst_valid", {127'b0, bus.valid}, 128'd0);
        check("rst_rd", bus.rd, 128'd0);

        // Store then load, unit stride.
        xfer("st0", 1'b1, 10'd0, 10'd1, {32'd1003, 32'd1002, 32'd1001, 32'd1000},
             16'hFFFF, 1'b0, rdv);
        xfer("ld0", 1'b0, 10'd0, 10'd1, '0, 16'h0000, 1'b0, rdv);
        check("ld0_rd", rdv, {32'd1003, 32'd1002, 32'd1001, 32'd1000});

        // Reset with a pending store request must not write memory.
        @(negedge clk);
        rst = 1'b1; bus.req = 1'b1; bus.we = 1'b1; bus.address = '0;
        bus.stride = 10'd1; bus.wd = {4{32'hDEADBEEF}}; bus.be = 16'hFFFF;
        @(negedge clk); @(negedge clk);
        rst = 1'b0; bus.req = 1'b0;
        xfer("ld_norst", 1'b0, 10'd0, 10'd1, '0, 16'h0000, 1'b0, rdv);
        check("rst_no_write", rdv, {32'd1003, 32'd1002, 32'd1001, 32'd1000});

        // Wrap-around past the top of memory.
        xfer("st_wrap", 1'b1, 10'd1022, 10'd1, {32'd10, 32'd9, 32'd8, 32'd7},
             16'hFFFF, 1'b0, rdv);
        xfer("ld_wrap", 1'b0, 10'd1022, 10'd1, '0, 16'h0000, 1'b0, rdv);
        check("wrap_rd_hi", rdv, {32'd10, 32'd9, 32'd8, 32'd7});
        xfer("ld_wrap0", 1'b0, 10'd0, 10'd1, '0, 16'h0000, 1'b0, rdv);
        check("wrap_rd_lo", rdv, {32'd1003, 32'd1002, 32'd10, 32'd9});

        // Byte enables on lane 0 only; other lanes have BE=0.
        xfer("st_be_full", 1'b1, 10'd5, 10'd1, {96'h0, 32'hAABBCCDD},
             16'h000F, 1'b0, rdv);
        xfer("st_be_part", 1'b1, 10'd5, 10'd1, {96'h0, 32'h11223344},
             16'h0005, 1'b0, rdv);
        xfer("ld_be", 1'b0, 10'd5, 10'd0, '0, 16'h0000, 1'b0, rdv);
        check("be_rd", rdv, {4{32'hAA22CC44}});

        // Stride-0 store collision with a REQ poked during BUSY.
        xfer("st_coll", 1'b1, 10'd9, 10'd0, {32'd4, 32'd3, 32'd2, 32'd1},
             16'hFFFF, 1'b1, rdv);
        check("store_keeps_rd", bus.rd, {4{32'hAA22CC44}});
        xfer("ld_coll", 1'b0, 10'd9, 10'd0, '0, 16'h0000, 1'b0, rdv);
        check("coll_rd", rdv, {4{32'd4}});

        // Abort a store after lane 1 has been written.
        xfer("st_ff", 1'b1, 10'd20, 10'd1, {4{32'hFF}}, 16'hFFFF, 1'b0, rdv);
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.address = 10'd20; bus.stride = 10'd1;
        bus.wd = {32'd4, 32'd3, 32'd2, 32'd1}; bus.be = 16'hFFFF;
        @(posedge clk);                       // e0: accept
        @(negedge clk); bus.req = 1'b0;
        vcnt = 0;
        @(posedge clk);                       // e0+1: lane 0
        @(posedge clk);                       // e0+2: lane 1
        @(negedge clk); rst = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            if (bus.valid) vcnt++;
        end
        check("abort_no_valid", 128'(vcnt), 128'd0);
        check("abort_ready", {127'b0, bus.ready}, 128'd1);
        check("abort_rd_cleared", bus.rd, 128'd0);
        xfer("ld_abort", 1'b0, 10'd20, 10'd1, '0, 16'h0000, 1'b0, rdv);
        check("abort_mem", rdv, {32'hFF, 32'hFF, 32'd2, 32'd1});

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
